// File: rtl/prbs_checker_if.sv
// Serial PRBS checker bus: received bit stream in, lock/error status out.
// The master side feeds bits; the slave side is the checker.
interface prbs_checker_if #(
  parameter int CW = 16
);
  logic          DIN;
  logic          DVALID;
  logic          CLR;
  logic          ERR;
  logic          LOCKED;
  logic [CW-1:0] ERR_CNT;

  modport master (
    output DIN, DVALID, CLR,
    input  ERR, LOCKED, ERR_CNT
  );

  modport slave (
    input  DIN, DVALID, CLR,
    output ERR, LOCKED, ERR_CNT
  );
endinterface

// File: rtl/prbs_checker.sv
// PRBS checker for polynomial x^N + x^TAP + 1: hunts for a consistent sequence,
// then free-runs a local generator and counts bit errors, dropping lock on error bursts.
module prbs_checker #(
  parameter int N         = 7,
  parameter int TAP       = 6,
  parameter int LOCK_TH   = 16,
  parameter int WIN       = 64,
  parameter int UNLOCK_TH = 8,
  parameter int CW        = 16
) (
  input  logic          CLK,
  input  logic          RSTX,
  prbs_checker_if.slave bus
);

  localparam int MW  = $clog2(LOCK_TH + 1);
  localparam int WBW = $clog2(WIN + 1);
  localparam int WEW = $clog2(UNLOCK_TH + 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state_p0, state_nxt;
  logic [N-1:0]   sr, sr_nxt;
  logic [MW-1:0]  match_cnt, match_nxt;
  logic [WBW-1:0] win_bits, win_bits_nxt, win_bits_inc;
  logic [WEW-1:0] win_errs, win_errs_nxt, win_errs_inc;
  logic           pred, bit_err, hunt_match;
  logic           err_p1, err_nxt, locked_p1;
  logic [CW-1:0]  err_cnt_p1, err_cnt_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign pred         = sr[N-1] ^ sr[TAP-1];
  assign bit_err      = bus.DIN ^ pred;
  // An all-zero register predicts zeros forever, so it must never count as agreement.
  assign hunt_match   = (|sr) && !bit_err;
  assign win_bits_inc = win_bits + WBW'(1);
  assign win_errs_inc = win_errs + WEW'(bit_err);

  always_comb begin
    state_nxt    = state_p0;
    sr_nxt       = sr;
    match_nxt    = match_cnt;
    win_bits_nxt = win_bits;
    win_errs_nxt = win_errs;
    err_nxt      = 1'b0;
    err_cnt_nxt  = err_cnt_p1;
    if (bus.DVALID) begin
      if (state_p0 == HUNT) begin
        sr_nxt = {sr[N-2:0], bus.DIN};
        if (hunt_match) begin
          if (match_cnt == MW'(LOCK_TH - 1)) begin
            state_nxt    = LOCK;
            match_nxt    = '0;
            win_bits_nxt = '0;
            win_errs_nxt = '0;
          end else begin
            match_nxt = match_cnt + MW'(1);
          end
        end else begin
          match_nxt = '0;
        end
      end else begin
        // Locked: the register regenerates the sequence itself, DIN is only compared.
        sr_nxt  = {sr[N-2:0], pred};
        err_nxt = bit_err;
        if (bit_err) err_cnt_nxt = sat_inc(err_cnt_p1);
        if (win_errs_inc == WEW'(UNLOCK_TH)) begin
          state_nxt    = HUNT;
          match_nxt    = '0;
          win_bits_nxt = '0;
          win_errs_nxt = '0;
        end else if (win_bits_inc == WBW'(WIN)) begin
          win_bits_nxt = '0;
          win_errs_nxt = '0;
        end else begin
          win_bits_nxt = win_bits_inc;
          win_errs_nxt = win_errs_inc;
        end
      end
    end
    if (bus.CLR) err_cnt_nxt = '0;
  end

  // Stage p0 -> p1: state, generator, counters and registered outputs
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_p0   <= HUNT;
      sr         <= '0;
      match_cnt  <= '0;
      win_bits   <= '0;
      win_errs   <= '0;
      err_p1     <= 1'b0;
      locked_p1  <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      state_p0   <= state_nxt;
      sr         <= sr_nxt;
      match_cnt  <= match_nxt;
      win_bits   <= win_bits_nxt;
      win_errs   <= win_errs_nxt;
      err_p1     <= err_nxt;
      locked_p1  <= (state_nxt == LOCK);
      err_cnt_p1 <= err_cnt_nxt;
    end
  end

  assign bus.ERR     = err_p1;
  assign bus.LOCKED  = locked_p1;
  assign bus.ERR_CNT = err_cnt_p1;

endmodule
